// File: rtl/fxp_addsub_pipe.sv
// Two-stage, multi-lane fixed-point add/sub with per-lane accumulator, valid/ready flow control
// and overflow event counter. Define FXP_ADDSUB_SAT_EN for saturating results (default: wrap).
module fxp_addsub_pipe #(
  parameter int C_FXP_LENGTH = 20,
  parameter int C_FXP_POINT  = 16,
  parameter int C_LANES      = 3
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [C_LANES*C_FXP_LENGTH-1:0]   S_NUM1,
  input  logic [C_LANES*C_FXP_LENGTH-1:0]   S_NUM2,
  input  logic [1:0]                        S_OPE,
  input  logic                              S_VALID,
  output logic                              S_READY,
  output logic [C_LANES*C_FXP_LENGTH-1:0]   M_RESULT,
  output logic [C_LANES-1:0]                M_OF_FLAG,
  output logic                              M_VALID,
  input  logic                              M_READY,
  output logic [15:0]                       OF_COUNT,
  input  logic                              OF_CLR
);

  localparam int L = C_FXP_LENGTH;
  localparam int W = C_LANES * C_FXP_LENGTH;

`ifdef FXP_ADDSUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  if (C_FXP_POINT < 0 || C_FXP_POINT >= C_FXP_LENGTH) begin : g_bad_point
    $error("fxp_addsub_pipe: C_FXP_POINT must lie in [0, C_FXP_LENGTH)");
  end

  // The (L+1)-bit sum never overflows itself; disagreement of its top two bits marks an
  // overflow of the L-bit result, and bit L carries the true sign for the saturation direction.
  function automatic logic [L-1:0] handle_of(input logic [L:0] raw);
    logic [L-1:0] sat_val;
    sat_val = raw[L] ? {1'b1, {(L-1){1'b0}}} : {1'b0, {(L-1){1'b1}}};
    if (SAT_EN && (raw[L] != raw[L-1])) handle_of = sat_val;
    else                                handle_of = raw[L-1:0];
  endfunction

  logic                         en;
  logic                         accept;
  logic signed [L:0]            opa;
  logic signed [L:0]            opb;
  logic signed [L:0]            b_ext;
  logic signed [L:0]            sum;

  logic [C_LANES-1:0][L:0]      raw_p1_q, raw_p1_d;
  logic [C_LANES-1:0]           of_p1_q, of_p1_d;
  logic                         vld_p1_q, vld_p1_d;
  logic [C_LANES-1:0][L-1:0]    acc_q, acc_d;
  logic [W-1:0]                 res_p2_q, res_p2_d;
  logic [C_LANES-1:0]           of_p2_q, of_p2_d;
  logic                         vld_p2_q, vld_p2_d;
  logic [15:0]                  of_count_q, of_count_d;

  always_comb begin
    en         = !vld_p2_q || M_READY;
    accept     = S_VALID && en;
    opa        = '0;
    opb        = '0;
    b_ext      = '0;
    sum        = '0;
    raw_p1_d   = raw_p1_q;
    of_p1_d    = of_p1_q;
    vld_p1_d   = vld_p1_q;
    acc_d      = acc_q;
    res_p2_d   = res_p2_q;
    of_p2_d    = of_p2_q;
    vld_p2_d   = vld_p2_q;
    of_count_d = of_count_q;

    // stage p1: operand select, widened sum, overflow detect, accumulator update
    for (int i = 0; i < C_LANES; i++) begin
      opa   = {S_NUM1[i*L + L-1], S_NUM1[i*L +: L]};
      b_ext = {S_NUM2[i*L + L-1], S_NUM2[i*L +: L]};
      case (S_OPE)
        2'b00:   opb = b_ext;
        2'b01:   opb = -b_ext;
        2'b10: begin
          opb = opa;
          opa = {acc_q[i][L-1], acc_q[i]};
        end
        default: opb = '0;
      endcase
      sum = opa + opb;
      if (accept) begin
        raw_p1_d[i] = sum;
        of_p1_d[i]  = sum[L] ^ sum[L-1];
        if (S_OPE[1]) acc_d[i] = handle_of(sum);
      end
    end

    // stage p2: overflow handling and output register
    if (en) begin
      vld_p1_d = S_VALID;
      vld_p2_d = vld_p1_q;
      of_p2_d  = of_p1_q;
      for (int i = 0; i < C_LANES; i++) begin
        res_p2_d[i*L +: L] = handle_of(raw_p1_q[i]);
      end
    end

    if (vld_p2_q && M_READY && (|of_p2_q) && (of_count_q != 16'hFFFF))
      of_count_d = of_count_q + 16'd1;
    if (OF_CLR) of_count_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      raw_p1_q   <= '0;
      of_p1_q    <= '0;
      vld_p1_q   <= 1'b0;
      acc_q      <= '0;
      res_p2_q   <= '0;
      of_p2_q    <= '0;
      vld_p2_q   <= 1'b0;
      of_count_q <= '0;
    end else begin
      raw_p1_q   <= raw_p1_d;
      of_p1_q    <= of_p1_d;
      vld_p1_q   <= vld_p1_d;
      acc_q      <= acc_d;
      res_p2_q   <= res_p2_d;
      of_p2_q    <= of_p2_d;
      vld_p2_q   <= vld_p2_d;
      of_count_q <= of_count_d;
    end
  end

  assign S_READY   = en;
  assign M_RESULT  = res_p2_q;
  assign M_OF_FLAG = of_p2_q;
  assign M_VALID   = vld_p2_q;
  assign OF_COUNT  = of_count_q;

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Scoreboard bench for fxp_addsub_pipe: integer reference model, randomized and directed beats.
// Honours FXP_ADDSUB_SAT_EN the same way as the design.
module tb_fxp_addsub_pipe;
  localparam int L = 20;
  localparam int N = 3;
  localparam int W = L * N;
  localparam longint MAXV = (64'sd1 <<< (L-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (L-1));

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [W-1:0]  S_NUM1 = '0;
  logic [W-1:0]  S_NUM2 = '0;
  logic [1:0]    S_OPE = '0;
  logic          S_VALID = 1'b0;
  logic          S_READY;
  logic [W-1:0]  M_RESULT;
  logic [N-1:0]  M_OF_FLAG;
  logic          M_VALID;
  logic          M_READY = 1'b1;
  logic [15:0]   OF_COUNT;
  logic          OF_CLR = 1'b0;

  fxp_addsub_pipe #(.C_FXP_LENGTH(L), .C_FXP_POINT(16), .C_LANES(N)) dut (
    .CLK(CLK), .RST(RST), .S_NUM1(S_NUM1), .S_NUM2(S_NUM2), .S_OPE(S_OPE),
    .S_VALID(S_VALID), .S_READY(S_READY), .M_RESULT(M_RESULT), .M_OF_FLAG(M_OF_FLAG),
    .M_VALID(M_VALID), .M_READY(M_READY), .OF_COUNT(OF_COUNT), .OF_CLR(OF_CLR)
  );

  typedef struct packed { logic [W-1:0] res; logic [N-1:0] of; } exp_t;
  typedef struct { int unsigned cyc; logic [W-1:0] res; logic [N-1:0] of; } log_t;

  exp_t        sbq[$];
  log_t        lg[$];
  longint      macc[N];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  bit          rnd_done = 1'b0;

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint wrap_s(input longint t);
    longint w;
    w = t & ((64'sd1 <<< L) - 1);
    if (w > MAXV) w = w - (64'sd1 <<< L);
    return w;
  endfunction

  // Reference: exact integer result, then clamp or wrap into L bits.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] op,
                                output logic [W-1:0] r, output logic [N-1:0] f);
    longint av, bv, t, v;
    logic [63:0] bits;
    r = '0;
    f = '0;
    for (int i = 0; i < N; i++) begin
      av = longint'($signed(a[i*L +: L]));
      bv = longint'($signed(b[i*L +: L]));
      case (op)
        2'd0:    t = av + bv;
        2'd1:    t = av - bv;
        2'd2:    t = macc[i] + av;
        default: t = av;
      endcase
      f[i] = (t > MAXV) || (t < MINV);
`ifdef FXP_ADDSUB_SAT_EN
      v = (t > MAXV) ? MAXV : ((t < MINV) ? MINV : t);
`else
      v = wrap_s(t);
`endif
      bits = v;
      r[i*L +: L] = bits[L-1:0];
      if (op[1]) macc[i] = v;
    end
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    logic [W-1:0] r;
    logic [N-1:0] f;
    int guard;
    @(posedge CLK); #1;
    S_NUM1 = a; S_NUM2 = b; S_OPE = op; S_VALID = 1'b1;
    guard = 0;
    forever begin
      @(negedge CLK);
      if (S_READY) begin
        model(a, b, op, r, f);
        sbq.push_back('{res: r, of: f});
        last_acc = cyc;
        break;
      end
      guard++;
      if (guard > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout: S_READY stayed %b, expected 1", S_READY);
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    S_VALID = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || M_VALID) && g < 300) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 300) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sbq.size());
    end
  endtask

  function automatic logic [W-1:0] lane0(input logic [L-1:0] v);
    logic [W-1:0] x;
    x = '0;
    x[L-1:0] = v;
    return x;
  endfunction

  function automatic logic [L-1:0] rnd_word();
    logic [L-1:0] w;
    case ($urandom_range(0, 3))
      0:       w = 20'h7FFFF - 20'($urandom_range(0, 4095));
      1:       w = 20'h80000 + 20'($urandom_range(0, 4095));
      default: w = 20'($urandom);
    endcase
    return w;
  endfunction

  // Monitor: pops the scoreboard on every output handshake, checks hold-while-stalled and OF_COUNT.
  initial begin
    exp_t        e;
    logic [W-1:0] pres;
    logic [N-1:0] pof;
    bit          pstall;
    int          exp_ofc;
    pstall = 1'b0; exp_ofc = 0; pres = '0; pof = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        sbq.delete();
        exp_ofc = 0;
        pstall = 1'b0;
      end else begin
        check("of_count", 64'(OF_COUNT), 64'(exp_ofc));
        if (pstall) begin
          check("hold_result", 64'(M_RESULT), 64'(pres));
          check("hold_of_flag", 64'(M_OF_FLAG), 64'(pof));
          check("hold_valid", 64'(M_VALID), 64'd1);
        end
        if (M_VALID && !M_READY) check("s_ready_stalled", 64'(S_READY), 64'd0);
        if (M_VALID && M_READY) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_output: got %h, expected no beat", M_RESULT);
          end else begin
            e = sbq.pop_front();
            check("result", 64'(M_RESULT), 64'(e.res));
            check("of_flag", 64'(M_OF_FLAG), 64'(e.of));
            lg.push_back('{cyc: cyc, res: M_RESULT, of: M_OF_FLAG});
            if ((|e.of) && exp_ofc != 65535) exp_ofc++;
          end
        end
        if (OF_CLR) exp_ofc = 0;
        pstall = M_VALID && !M_READY;
        pres = M_RESULT;
        pof = M_OF_FLAG;
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) macc[i] = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_m_valid", 64'(M_VALID), 64'd0);
    check("reset_s_ready", 64'(S_READY), 64'd1);
    check("reset_result", 64'(M_RESULT), 64'd0);
    check("reset_of_flag", 64'(M_OF_FLAG), 64'd0);

    // 1: plain add and latency
    lg.delete();
    send(lane0(20'h18000), lane0(20'h24000), 2'b00);
    idle(); drain();
    check("t1_count", 64'(lg.size()), 64'd1);
    if (lg.size() == 1) begin
      check("t1_result", 64'(lg[0].res), 64'(lane0(20'h3C000)));
      check("t1_flag", 64'(lg[0].of), 64'd0);
      check("t1_latency", 64'(lg[0].cyc - last_acc), 64'd2);
    end

    // 2: positive overflow on add
    lg.delete();
    send(lane0(20'h70000), lane0(20'h10000), 2'b00);
    idle(); drain();
    if (lg.size() == 1) begin
`ifdef FXP_ADDSUB_SAT_EN
      check("t2_result", 64'(lg[0].res), 64'(lane0(20'h7FFFF)));
`else
      check("t2_result", 64'(lg[0].res), 64'(lane0(20'h80000)));
`endif
      check("t2_flag", 64'(lg[0].of), 64'd1);
    end else check("t2_count", 64'(lg.size()), 64'd1);
    check("t2_of_count", 64'(OF_COUNT), 64'd1);

    // 3: negative overflow on subtract
    lg.delete();
    send(lane0(20'h80000), lane0(20'h10000), 2'b01);
    idle(); drain();
    if (lg.size() == 1) begin
`ifdef FXP_ADDSUB_SAT_EN
      check("t3_result", 64'(lg[0].res), 64'(lane0(20'h80000)));
`else
      check("t3_result", 64'(lg[0].res), 64'(lane0(20'h70000)));
`endif
      check("t3_flag", 64'(lg[0].of), 64'd1);
    end else check("t3_count", 64'(lg.size()), 64'd1);

    // 4: load then back-to-back accumulate
    lg.delete();
    send(lane0(20'h10000), '0, 2'b11);
    for (int k = 0; k < 3; k++) send(lane0(20'h08000), '0, 2'b10);
    idle(); drain();
    check("t4_count", 64'(lg.size()), 64'd4);
    if (lg.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t4_result", 64'(lg[k].res), 64'(lane0(20'h10000 + 20'(k) * 20'h08000)));
        if (k > 0) check("t4_consecutive", 64'(lg[k].cyc - lg[k-1].cyc), 64'd1);
      end
    end

    // 5: backpressure during a 5-beat stream
    lg.delete();
    fork
      begin
        for (int k = 0; k < 5; k++) send(lane0(20'(k) * 20'h01000 + 20'h1), lane0(20'h00100), 2'b00);
        idle();
      end
      begin
        repeat (3) @(posedge CLK);
        #1 M_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1 M_READY = 1'b1;
      end
    join
    drain();
    check("t5_count", 64'(lg.size()), 64'd5);
    if (lg.size() == 5)
      for (int k = 0; k < 5; k++)
        check("t5_order", 64'(lg[k].res), 64'(lane0(20'(k) * 20'h01000 + 20'h101)));

    // random traffic with random downstream readiness
    fork
      begin
        while (!rnd_done) begin
          @(posedge CLK); #1;
          M_READY = ($urandom_range(0, 3) != 0);
        end
        M_READY = 1'b1;
      end
    join_none
    for (int k = 0; k < 300; k++) begin
      logic [W-1:0] a, b;
      for (int i = 0; i < N; i++) begin
        a[i*L +: L] = rnd_word();
        b[i*L +: L] = rnd_word();
      end
      send(a, b, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle(); drain();
    rnd_done = 1'b1;
    repeat (2) @(posedge CLK);
    #1 M_READY = 1'b1;

    // 6: reset with beats in flight, then clear colliding with an overflow handshake
    send(lane0(20'h00011), lane0(20'h00022), 2'b11);
    send(lane0(20'h00033), lane0(20'h00044), 2'b10);
    @(posedge CLK); #1;
    S_VALID = 1'b0; RST = 1'b1;
    for (int i = 0; i < N; i++) macc[i] = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("t6_m_valid_after_rst", 64'(M_VALID), 64'd0);
    check("t6_s_ready_after_rst", 64'(S_READY), 64'd1);
    lg.delete();
    send(lane0(20'h00123), '0, 2'b10);
    idle(); drain();
    if (lg.size() == 1) check("t6_acc_cleared", 64'(lg[0].res), 64'(lane0(20'h00123)));
    else check("t6_count", 64'(lg.size()), 64'd1);

    @(posedge CLK); #1 OF_CLR = 1'b1;
    send(lane0(20'h70000), lane0(20'h10000), 2'b00);
    idle(); drain();
    @(posedge CLK); #1 OF_CLR = 1'b0;
    @(negedge CLK);
    check("t6_clr_wins", 64'(OF_COUNT), 64'd0);
    send(lane0(20'h70000), lane0(20'h10000), 2'b00);
    idle(); drain();
    check("t6_count_after_clr", 64'(OF_COUNT), 64'd1);

    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fxp_addsub_pipe.md
# fxp_addsub_pipe

Pipelined, multi-lane fixed-point adder/subtractor with a per-lane accumulator, valid/ready handshake and an overflow event counter. It is the next generation of the combinational `fxp_adder` used in the inverse-kinematics datapath. It processes all coordinate lanes of a leg (x, y, z) per beat and can sit between registered pipeline stages without external glue.

## Interface
Parameters:
- `C_FXP_LENGTH`, 20: word width, two's complement.
- `C_FXP_POINT`, 16: fractional bits. Carried for consistency only; it does not change add/sub arithmetic.
- `C_LANES`, 3: number of independent lanes.

Ports:
- `CLK`  in  1  system clock; everything is rising-edge.
- `RST`  in  1  synchronous, active-high reset.
- `S_NUM1`  in  `C_LANES*C_FXP_LENGTH`  operand A; lane i is at bits `[i*L +: L]`.
- `S_NUM2`  in  `C_LANES*C_FXP_LENGTH`  operand B.
- `S_OPE`  in  2  operation, common to all lanes:
  - 00: A+B
  - 01: A−B
  - 10: ACC+A
  - 11: load A
- `S_VALID`  in  1  input beat valid.
- `S_READY`  out  1  input beat accepted when `S_VALID && S_READY`.
- `M_RESULT`  out  `C_LANES*C_FXP_LENGTH`  result, same lane packing as the inputs.
- `M_OF_FLAG`  out  `C_LANES`  per-lane overflow of this beat.
- `M_VALID`  out  1  output beat valid.
- `M_READY`  in  1  downstream ready.
- `OF_COUNT`  out  16  number of output beats with any overflow.
- `OF_CLR`  in  1  synchronous clear of `OF_COUNT`.

## Operation
- Pipeline enable: `en = !M_VALID || M_READY`. `S_READY = en`, combinational. A stall freezes both stages together.
- Stage 1, on accept: per lane, registers the (L+1)-bit raw sum and the overflow flag; marks stage-1 valid.
  - Operand selection: A op B for codes 00/01; ACC + A for code 10; A + 0 for code 11.
  - Overflow rule: operand signs equal (with B negated for subtract) and the sign of the raw sum differs.
- Stage 2, when `en`: applies overflow handling (see Configuration), registers `M_RESULT`/`M_OF_FLAG`, and sets `M_VALID` to the stage-1 valid.
- Accumulator (one per lane, L bits):
  - Updated only on an accepted beat with code 10 or 11.
  - Takes the same post-handling value that the beat will present on `M_RESULT`. It is computed in stage 1, so back-to-back accumulate beats need no bubbles.
  - Codes 00/01 leave the accumulator unchanged.
- `OF_COUNT`: +1 on each output handshake (`M_VALID && M_READY`) where `|M_OF_FLAG` is set.
  - Saturates at 16'hFFFF.
  - `OF_CLR` clears it; clear wins over a simultaneous increment.
- Reset:
  - All registers go to 0: `M_RESULT`, `M_OF_FLAG`, `M_VALID`, `OF_COUNT`, accumulators, stage-1 valid.
  - `S_READY` reads 1 in the cycle after reset is released.
  - Reset mid-operation drops in-flight beats; nothing is emitted for them.

## Timing
- Latency: 2 cycles from the accept edge to `M_VALID` with the result, when unstalled.
- Throughput: 1 beat/cycle.
- While `M_VALID && !M_READY`:
  - `M_RESULT`, `M_OF_FLAG` and `M_VALID` hold stable.
  - `S_READY` = 0; stage 1 holds; accumulators do not change.
- `M_VALID` never drops without a handshake, except under `RST`.
- Bubbles: an empty stage 2 is refilled on the same edge that empties stage 1; there are no internal bubbles.

## Configuration
- `FXP_ADDSUB_SAT_EN` defined: on overflow, the lane result saturates.
  - Positive overflow → 2^(L−1)−1 (0x7FFFF at L=20).
  - Negative overflow → −2^(L−1) (0x80000).
- Undefined: two's-complement wrap, i.e. the low L bits of the raw sum (legacy `fxp_adder` behaviour).
- `M_OF_FLAG` and `OF_COUNT` behave identically in both builds.

## Test plan
All cases use L=20, P=16, 3 lanes.
1. Add, code 00: lane0 = 0x18000 + 0x24000 → 0x3C000, flag 0, `M_VALID` exactly 2 cycles after accept.
2. Overflow, code 00: 0x70000 + 0x10000.
   - Wrap build → 0x80000.
   - Sat build → 0x7FFFF.
   - Flag 1 on that lane, `OF_COUNT` = 1.
3. Subtract, code 01: 0x80000 − 0x10000.
   - Wrap build → 0x70000.
   - Sat build → 0x80000.
   - Flag 1.
4. Accumulate, back-to-back beats: code 11 with A = 0x10000, then three code-10 beats with A = 0x08000 → outputs 0x10000, 0x18000, 0x20000, 0x28000 on consecutive cycles.
5. Backpressure: stream 5 beats with `M_READY` low for cycles 3–5.
   - All 5 results arrive in order, none lost or duplicated.
   - Outputs stay stable while stalled; `S_READY` = 0 while stalled.
6. `RST` asserted with 2 beats in flight → `M_VALID` = 0 and accumulators 0 next cycle. `OF_CLR` and an overflow handshake in the same cycle → `OF_COUNT` = 0.
